// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the instruction ROM read port between the IF and MEM
// stages, with fixed priority, a starvation guard and one-cycle responses.
module rom_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int MAX_WAIT  = 3,
  parameter bit MEM_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic              if_valid,
  output logic [31:0]       if_data,
  input  logic              if_flush,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_grant,
  output logic              mem_valid,
  output logic [31:0]       mem_data,
  output logic              mem_misaligned,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [31:0]       rom_out
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  // consecutive lost grants per requester
  logic [3:0] if_wait;
  logic [3:0] mem_wait;

  // pick at most one winner; a starved loser overrides the default priority
  always_comb begin
    if_grant  = 1'b0;
    mem_grant = 1'b0;
    if (!reset) begin
      if (if_req && mem_req) begin
        if (MEM_FIRST) begin
          if (if_wait == WAIT_LIMIT) begin
            if_grant = 1'b1;
          end else begin
            mem_grant = 1'b1;
          end
        end else begin
          if (mem_wait == WAIT_LIMIT) begin
            mem_grant = 1'b1;
          end else begin
            if_grant = 1'b1;
          end
        end
      end else if (if_req) begin
        if_grant = 1'b1;
      end else if (mem_req) begin
        mem_grant = 1'b1;
      end
    end
  end

  // the ROM is always read word-aligned; idle cycles present address zero
  always_comb begin
    rom_address = '0;
    if (mem_grant) begin
      rom_address = {mem_addr[ADDR_W-1:2], 2'b00};
    end else if (if_grant) begin
      rom_address = {if_addr[ADDR_W-1:2], 2'b00};
    end
  end

  // register the ROM word for whichever side won; a flush only hides the valid
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid       <= 1'b0;
      if_data        <= '0;
      mem_valid      <= 1'b0;
      mem_data       <= '0;
      mem_misaligned <= 1'b0;
    end else begin
      if_valid       <= if_grant && !if_flush;
      mem_valid      <= mem_grant;
      mem_misaligned <= mem_grant && (mem_addr[1:0] != 2'b00);
      if (if_grant) begin
        if_data <= rom_out;
      end
      if (mem_grant) begin
        mem_data <= rom_out;
      end
    end
  end

  // count lost grants, saturating at the limit, cleared on win or idle
  always_ff @(posedge clk) begin
    if (reset) begin
      if_wait  <= '0;
      mem_wait <= '0;
    end else begin
      if (if_req && !if_grant) begin
        if (if_wait < WAIT_LIMIT) begin
          if_wait <= if_wait + 4'd1;
        end
      end else begin
        if_wait <= '0;
      end
      if (mem_req && !mem_grant) begin
        if (mem_wait < WAIT_LIMIT) begin
          mem_wait <= mem_wait + 4'd1;
        end
      end else begin
        mem_wait <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed vectors for rom_arbiter with a simple ROM whose
// word at any aligned address is {16'hC0DE, address}.
module tb_rom_arbiter;

  localparam int ADDR_W = 16;

  logic              clk;
  logic              reset;
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifGrant;
  logic              ifValid;
  logic [31:0]       ifData;
  logic              ifFlush;
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memGrant;
  logic              memValid;
  logic [31:0]       memData;
  logic              memMisaligned;
  logic [ADDR_W-1:0] romAddress;
  logic [31:0]       romOut;

  int vectorCount;
  int missCount;

  rom_arbiter #(
    .ADDR_W(ADDR_W),
    .MAX_WAIT(3),
    .MEM_FIRST(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(ifReq),
    .if_addr(ifAddr),
    .if_grant(ifGrant),
    .if_valid(ifValid),
    .if_data(ifData),
    .if_flush(ifFlush),
    .mem_req(memReq),
    .mem_addr(memAddr),
    .mem_grant(memGrant),
    .mem_valid(memValid),
    .mem_data(memData),
    .mem_misaligned(memMisaligned),
    .rom_address(romAddress),
    .rom_out(romOut)
  );

  // combinational ROM contents
  assign romOut = {16'hC0DE, romAddress};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ir, input logic [ADDR_W-1:0] ia,
                               input logic fl, input logic mr, input logic [ADDR_W-1:0] ma);
    reset   = rst;
    ifReq   = ir;
    ifAddr  = ia;
    ifFlush = fl;
    memReq  = mr;
    memAddr = ma;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // both sides requesting: expect MEM x3 then IF, repeating, each answered next cycle
  task automatic runContention(input int cycles, input logic [ADDR_W-1:0] ia,
                               input logic [ADDR_W-1:0] ma);
    logic expIf;
    for (int i = 0; i < cycles; i++) begin
      expIf = ((i % 4) == 3);
      checkOutput("contendIfGrant", 32'(ifGrant), 32'(expIf));
      checkOutput("contendMemGrant", 32'(memGrant), 32'(!expIf));
      checkOutput("contendRomAddr", 32'(romAddress), expIf ? 32'(ia) : 32'(ma));
      nextCycle();
      checkOutput("contendIfValid", 32'(ifValid), 32'(expIf));
      checkOutput("contendMemValid", 32'(memValid), 32'(!expIf));
      if (expIf) begin
        checkOutput("contendIfData", ifData, {16'hC0DE, ia});
      end else begin
        checkOutput("contendMemData", memData, {16'hC0DE, ma});
      end
    end
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;

    $display("[TB] reset held with both requests");
    applyStimulus(1'b1, 1'b1, 16'h0020, 1'b0, 1'b1, 16'h0030);
    nextCycle();
    checkOutput("rstIfGrant", 32'(ifGrant), 32'd0);
    checkOutput("rstMemGrant", 32'(memGrant), 32'd0);
    checkOutput("rstRomAddr", 32'(romAddress), 32'd0);
    nextCycle();
    checkOutput("rstIfValid", 32'(ifValid), 32'd0);
    checkOutput("rstMemValid", 32'(memValid), 32'd0);
    checkOutput("rstIfData", ifData, 32'd0);
    checkOutput("rstMemData", memData, 32'd0);
    checkOutput("rstMisaligned", 32'(memMisaligned), 32'd0);

    $display("[TB] release reset, grant in the same cycle");
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0, 1'b1, 16'h0030);
    checkOutput("relMemGrant", 32'(memGrant), 32'd1);
    checkOutput("relIfGrant", 32'(ifGrant), 32'd0);
    checkOutput("relRomAddr", 32'(romAddress), 32'h0030);
    nextCycle();
    checkOutput("relMemValid", 32'(memValid), 32'd1);
    checkOutput("relMemData", memData, 32'hC0DE0030);

    $display("[TB] IF alone at 0x8");
    applyStimulus(1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 16'h0000);
    checkOutput("ifAloneGrant", 32'(ifGrant), 32'd1);
    checkOutput("ifAloneRomAddr", 32'(romAddress), 32'h0008);
    nextCycle();
    checkOutput("ifAloneValid", 32'(ifValid), 32'd1);
    checkOutput("ifAloneData", ifData, 32'hC0DE0008);
    checkOutput("ifAloneMemValid", 32'(memValid), 32'd0);

    $display("[TB] contention with starvation guard");
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050);
    runContention(8, 16'h0040, 16'h0050);

    $display("[TB] misaligned MEM load at 0x6");
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006);
    checkOutput("misMemGrant", 32'(memGrant), 32'd1);
    checkOutput("misRomAddr", 32'(romAddress), 32'h0004);
    nextCycle();
    checkOutput("misMemValid", 32'(memValid), 32'd1);
    checkOutput("misFlag", 32'(memMisaligned), 32'd1);
    checkOutput("misMemData", memData, 32'hC0DE0004);
    checkOutput("misIfValid", 32'(ifValid), 32'd0);

    $display("[TB] flushed fetch at 0xC, then clean fetch at 0x10");
    applyStimulus(1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, 16'h0000);
    checkOutput("flushGrant", 32'(ifGrant), 32'd1);
    checkOutput("flushRomAddr", 32'(romAddress), 32'h000C);
    nextCycle();
    checkOutput("flushIfValid", 32'(ifValid), 32'd0);
    checkOutput("flushIfData", ifData, 32'hC0DE000C);
    checkOutput("flushMemValid", 32'(memValid), 32'd0);
    checkOutput("flushMisaligned", 32'(memMisaligned), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000);
    checkOutput("refetchGrant", 32'(ifGrant), 32'd1);
    nextCycle();
    checkOutput("refetchValid", 32'(ifValid), 32'd1);
    checkOutput("refetchData", ifData, 32'hC0DE0010);

    $display("[TB] reset on the edge after a grant");
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0, 1'b1, 16'h0024);
    nextCycle();
    nextCycle();
    checkOutput("preRstMemGrant", 32'(memGrant), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h0020, 1'b0, 1'b1, 16'h0024);
    checkOutput("midRstMemGrant", 32'(memGrant), 32'd0);
    checkOutput("midRstRomAddr", 32'(romAddress), 32'd0);
    nextCycle();
    checkOutput("midRstMemValid", 32'(memValid), 32'd0);
    checkOutput("midRstIfValid", 32'(ifValid), 32'd0);
    checkOutput("midRstMemData", memData, 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0, 1'b1, 16'h0024);
    runContention(4, 16'h0020, 16'h0024);

    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    nextCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
